// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_state_e;

  localparam logic [2:0] PprotPrivileged  = 3'b001;
  localparam logic [2:0] PprotNonsecure   = 3'b010;
  localparam logic [2:0] PprotInstruction = 3'b100;

  localparam int unsigned TimeoutCyclesDefault = 255;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter; expire pulses on the wait cycle that reaches LIMIT.
module apb_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic incr,
  output logic expire
);

  localparam int unsigned Width = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

  logic [Width-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset || load) begin
      count_q <= '0;
    end else if (incr) begin
      count_q <= count_q + Width'(1);
    end
  end

  // Fires when this wait cycle would bring the count up to LIMIT.
  assign expire = incr && (count_q == Width'(LIMIT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request/response to APB4 initiator, one transfer at a time.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES without pready.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_write,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [2:0]          req_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pready,
  input  logic                out_pslverr
);

  apb_state_e state_q, state_d;

  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] strb_q;
  logic [2:0]          prot_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                timeout;

`ifdef APB_TIMEOUT_EN
  apb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clock  (clock),
    .reset  (reset),
    .load   (state_q == StSetup),
    .incr   ((state_q == StAccess) && !out_pready),
    .expire (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (out_pready || timeout) state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        // Read transfers carry no write data or strobes onto the bus.
        wdata_q <= req_write ? req_wdata : '0;
        strb_q  <= req_write ? req_wstrb : '0;
        prot_q  <= req_prot;
      end
      if (state_q == StAccess) begin
        if (out_pready) begin
          rdata_q <= write_q ? '0 : out_prdata;
          err_q   <= out_pslverr;
        end else if (timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign out_psel    = (state_q == StSetup) || (state_q == StAccess);
  assign out_penable = (state_q == StAccess);
  assign out_pprot   = prot_q;
  assign out_paddr   = addr_q;
  assign out_pwrite  = write_q;
  assign out_pwdata  = wdata_q;
  assign out_pstrb   = strb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge against a transaction-level model.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int unsigned To = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
  logic [2:0]  out_pprot;
  logic [31:0] out_paddr, out_pwdata, out_prdata;
  logic [3:0]  out_pstrb;

  int n_checks = 0;
  int n_errors = 0;

  apb_master_bridge #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (To)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .req_prot    (req_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .out_psel    (out_psel),
    .out_penable (out_penable),
    .out_pprot   (out_pprot),
    .out_paddr   (out_paddr),
    .out_pwrite  (out_pwrite),
    .out_pwdata  (out_pwdata),
    .out_pstrb   (out_pstrb),
    .out_prdata  (out_prdata),
    .out_pready  (out_pready),
    .out_pslverr (out_pslverr)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_bus(input string ph, input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
    check_eq({ph, "_paddr"}, out_paddr, a);
    check_eq({ph, "_pwrite"}, out_pwrite, w);
    check_eq({ph, "_pwdata"}, out_pwdata, w ? wd : 32'h0);
    check_eq({ph, "_pstrb"}, out_pstrb, w ? st : 4'h0);
    check_eq({ph, "_pprot"}, out_pprot, pr);
  endtask

  // w: wait states before pready; bp: cycles rsp_ready is held low.
  task automatic do_txn(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int w,
                        input logic perr, input logic [31:0] rd, input int bp);
    bit     aborted;
    int     n_acc;
    logic [31:0] exp_rd;
    logic        exp_err;
`ifdef APB_TIMEOUT_EN
    aborted = (w >= int'(To));
`else
    aborted = 1'b0;
`endif
    n_acc   = aborted ? int'(To) : w + 1;
    exp_rd  = (wr || aborted) ? 32'h0 : rd;
    exp_err = aborted ? 1'b1 : perr;

    req_valid = 1'b1;
    req_addr  = a;
    req_write = wr;
    req_wdata = wd;
    req_wstrb = st;
    req_prot  = pr;
    check_eq("idle_req_ready", req_ready, 1'b1);
    check_eq("idle_psel", out_psel, 1'b0);
    step();
    // Garbage on the request channel must be ignored from here on.
    req_addr   = $urandom;
    req_write  = ~wr;
    req_wdata  = $urandom;
    req_wstrb  = 4'($urandom);
    req_prot   = 3'($urandom);
    out_pready = 1'($urandom);
    out_pslverr = 1'($urandom);
    check_eq("setup_psel", out_psel, 1'b1);
    check_eq("setup_penable", out_penable, 1'b0);
    check_eq("setup_req_ready", req_ready, 1'b0);
    check_bus("setup", a, wr, wd, st, pr);
    step();
    for (int i = 0; i < n_acc; i++) begin
      bit last = !aborted && (i == w);
      out_pready  = last;
      out_pslverr = last ? perr : 1'($urandom);
      out_prdata  = last ? rd : $urandom;
      check_eq("access_psel", out_psel, 1'b1);
      check_eq("access_penable", out_penable, 1'b1);
      check_eq("access_rsp_valid", rsp_valid, 1'b0);
      check_bus("access", a, wr, wd, st, pr);
      step();
    end
    out_pready  = 1'b0;
    out_pslverr = 1'b0;
    for (int b = 0; b <= bp; b++) begin
      rsp_ready = (b == bp);
      req_valid = 1'($urandom);
      check_eq("resp_valid", rsp_valid, 1'b1);
      check_eq("resp_rdata", rsp_rdata, exp_rd);
      check_eq("resp_err", rsp_err, exp_err);
      check_eq("resp_psel", out_psel, 1'b0);
      check_eq("resp_req_ready", req_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check_eq("post_req_ready", req_ready, 1'b1);
    check_eq("post_rsp_valid", rsp_valid, 1'b0);
    check_eq("post_psel", out_psel, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_write   = 1'b0;
    req_wdata   = '0;
    req_wstrb   = '0;
    req_prot    = '0;
    rsp_ready   = 1'b0;
    out_prdata  = '0;
    out_pready  = 1'b0;
    out_pslverr = 1'b0;
    step();
    step();
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    check_eq("rst_psel", out_psel, 1'b0);
    check_eq("rst_penable", out_penable, 1'b0);
    check_bus("rst", 32'h0, 1'b0, 32'h0, 4'h0, 3'h0);
    reset = 1'b0;
    step();

    do_txn(32'h1000_0003, 1'b1, 32'h4100_0000, 4'b1000, 3'b000, 0, 1'b0, 32'h0, 0);
    do_txn(32'h1000_0005, 1'b0, 32'h0, 4'hF, PprotPrivileged, 3, 1'b0, 32'h6060_6060, 0);
    do_txn(32'h1000_0005, 1'b0, 32'h0, 4'h0, PprotNonsecure, 2, 1'b1, 32'hDEAD_BEEF, 0);
    do_txn(32'h2000_0010, 1'b0, 32'h0, 4'h0, PprotInstruction, 1, 1'b0, 32'h1234_5678, 5);
    do_txn(32'h2000_0014, 1'b0, 32'h0, 4'h0, 3'b000, int'(To) - 1, 1'b0, 32'hCAFE_0001, 0);
    do_txn(32'h2000_0018, 1'b0, 32'h0, 4'h0, 3'b000, int'(To) + 2, 1'b0, 32'hCAFE_0002, 1);

    for (int k = 0; k < 40; k++) begin
      do_txn($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
             int'($urandom_range(0, 6)), 1'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of an ACCESS phase with pready low.
    req_valid = 1'b1;
    req_addr  = 32'hA5A5_0000;
    req_write = 1'b1;
    req_wdata = 32'h5555_AAAA;
    req_wstrb = 4'hF;
    req_prot  = 3'b011;
    step();
    req_valid  = 1'b0;
    out_pready = 1'b0;
    step();
    check_eq("mid_access_penable", out_penable, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midrst_psel", out_psel, 1'b0);
    check_eq("midrst_penable", out_penable, 1'b0);
    check_eq("midrst_req_ready", req_ready, 1'b1);
    check_bus("midrst", 32'h0, 1'b0, 32'h0, 4'h0, 3'h0);
    for (int i = 0; i < 6; i++) begin
      out_pready = 1'b1;
      check_eq("midrst_no_rsp", rsp_valid, 1'b0);
      step();
    end
    out_pready = 1'b0;

    do_txn(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0BAD_F00D, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
